// File: rtl/inst_fetch_if.sv
// Instruction-fetch bus: memory request/response plus the decode handshake
// and the branch redirect.
// master: the fetch unit. slave: the memory/decode side.
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic [ADDR_W-1:0] prog_count;
    logic [INST_W-1:0] inst_in;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] pc_out;
    logic              out_valid;
    logic              out_ready;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              done;

    modport master (
        output prog_count, inst_out, pc_out, out_valid, done,
        input  inst_in, out_ready, branch_taken, branch_target
    );

    modport slave (
        input  prog_count, inst_out, pc_out, out_valid, done,
        output inst_in, out_ready, branch_taken, branch_target
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end. It presents a word index to a combinational
// instruction memory and captures the response into a small prefetch FIFO.
// The FIFO head is handed to decode over a valid/ready handshake. A branch
// redirect flushes the FIFO and restarts fetch at the target. done is raised
// once the last word has been issued and drained.
module inst_fetch_unit #(
    parameter int ADDR_W    = 32,
    parameter int INST_W    = 32,
    parameter int DEPTH     = 2,
    parameter int MEM_DEPTH = 16,
    parameter int RESET_PC  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [ADDR_W-1:0] MEM_LIM  = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_pc;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;

    logic [INST_W-1:0] r_fifo_inst [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];

    logic              w_out_valid;
    logic              w_pop;
    logic              w_push;

    // The head is only meaningful while the FIFO holds something.
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & bus.out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a new word while decode drains the head. Fetch never runs past the end
    // of memory, even if a redirect landed there.
    assign w_push      = (r_state == S_FETCH) & ~bus.branch_taken &
                         (r_pc < MEM_LIM) & ((r_count < CNT_FULL) | w_pop);

    // Occupancy update; a redirect empties the FIFO and swallows any pop.
    always_comb begin
        w_count_next = r_count;
        if (bus.branch_taken) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a redirect decides the state on its own; otherwise
    // fetch ends after the last word and drain ends when the FIFO empties.
    always_comb begin
        w_state_next = r_state;
        if (bus.branch_taken) begin
            w_state_next = (bus.branch_target < MEM_LIM) ? S_FETCH : S_DRAIN;
        end else begin
            case (r_state)
                S_FETCH: if (w_push && (r_pc == LAST_IDX)) w_state_next = S_DRAIN;
                S_DRAIN: if (w_count_next == '0)           w_state_next = S_DONE;
                S_DONE:  w_state_next = S_DONE;
                default: w_state_next = S_FETCH;
            endcase
        end
    end

    // Outputs derived from the state and the FIFO occupancy.
    always_comb begin
        bus.out_valid = w_out_valid;
        bus.done      = (r_state == S_DONE);
    end

    // Program counter, FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc     <= PC_INIT;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (bus.branch_taken) begin
                r_pc     <= bus.branch_target;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_pc     <= r_pc + ADDR_W'(1);
                    r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // FIFO storage: captures the memory response alongside its word index.
    // Contents are qualified by the occupancy count, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= bus.inst_in;
            r_fifo_pc[r_wr_ptr]   <= r_pc;
        end
    end

    assign bus.prog_count = r_pc;
    assign bus.inst_out   = r_fifo_inst[r_rd_ptr];
    assign bus.pc_out     = r_fifo_pc[r_rd_ptr];
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: a queue-based reference model, a per-cycle
// compare process, and directed scenarios with literal expectations.
module tb_inst_fetch_unit;
    localparam int DEPTH = 2;
    localparam int MEMD  = 16;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    inst_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

    inst_fetch_unit #(
        .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .MEM_DEPTH(MEMD), .RESET_PC(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a distinct word for every index.
    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return 32'h8B00_0000 ^ (idx * 32'h0101_0013);
    endfunction

    assign bus.inst_in = (bus.prog_count < 32'(MEMD)) ? mem_word(bus.prog_count) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the prefetch FIFO is a queue of (index, word) pairs.
    // mode 0 = fetching, 1 = draining, 2 = finished.
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    logic [31:0] m_pc = 0;
    int          m_mode = 0;
    bit          m_live = 0;

    always @(posedge clk) begin
        bit pop, push;
        if (!rst_n) begin
            q_pc.delete();
            q_inst.delete();
            m_pc   = 0;
            m_mode = 0;
            m_live = 1;
        end else if (bus.branch_taken) begin
            q_pc.delete();
            q_inst.delete();
            m_pc   = bus.branch_target;
            m_mode = (bus.branch_target < 32'(MEMD)) ? 0 : 1;
        end else begin
            pop  = (q_pc.size() > 0) && bus.out_ready;
            push = (m_mode == 0) && (m_pc < 32'(MEMD)) && ((q_pc.size() < DEPTH) || pop);
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (push) begin
                q_pc.push_back(m_pc);
                q_inst.push_back(mem_word(m_pc));
                if (m_pc == 32'(MEMD - 1)) m_mode = 1;
                m_pc = m_pc + 1;
            end
            else if (m_mode == 1 && q_pc.size() == 0) m_mode = 2;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("out_valid", 64'(bus.out_valid), 64'(q_pc.size() != 0));
            check("done", 64'(bus.done), 64'(m_mode == 2));
            check("prog_count", 64'(bus.prog_count), 64'(m_pc));
            if (q_pc.size() != 0) begin
                check("pc_out", 64'(bus.pc_out), 64'(q_pc[0]));
                check("inst_out", 64'(bus.inst_out), 64'(q_inst[0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        bus.branch_taken  = 1'b1;
        bus.branch_target = tgt;
        tick();
        bus.branch_taken  = 1'b0;
    endtask

    initial begin
        bit [7:0] pat;
        rst_n             = 1'b0;
        bus.out_ready     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        repeat (2) tick();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_pc", 64'(bus.prog_count), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);

        // T1: stream with decode always ready
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        check("t1_first_valid", 64'(bus.out_valid), 64'd1);
        check("t1_first_pc", 64'(bus.pc_out), 64'd0);
        check("t1_first_inst", 64'(bus.inst_out), 64'(mem_word(0)));
        for (int i = 1; i < 16; i++) begin
            tick();
            check("t1_stream_pc", 64'(bus.pc_out), 64'(i));
        end
        check("t1_pc_end", 64'(bus.prog_count), 64'd16);
        tick();
        check("t1_done", 64'(bus.done), 64'd1);
        check("t1_empty", 64'(bus.out_valid), 64'd0);

        // T2: backpressure after reset
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("t2_pc_hold", 64'(bus.prog_count), 64'd2);
        check("t2_head_pc", 64'(bus.pc_out), 64'd0);
        check("t2_head_inst", 64'(bus.inst_out), 64'(mem_word(0)));

        // T3: full FIFO, one simultaneous push and pop
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t3_pc", 64'(bus.prog_count), 64'd3);
        check("t3_head", 64'(bus.pc_out), 64'd1);
        tick();
        check("t3_stable_head", 64'(bus.pc_out), 64'd1);
        check("t3_stable_pc", 64'(bus.prog_count), 64'd3);
        bus.out_ready = 1'b1;
        for (int e = 2; e <= 13; e++) begin
            tick();
            check("t3_resume_pc", 64'(bus.pc_out), 64'(e));
        end

        // T4: branch to 12 while 13 is at the head
        redirect(32'd12);
        check("t4_flush_valid", 64'(bus.out_valid), 64'd0);
        check("t4_target_pc", 64'(bus.prog_count), 64'd12);
        for (int e = 12; e <= 15; e++) begin
            tick();
            check("t4_after_branch_pc", 64'(bus.pc_out), 64'(e));
        end
        tick();
        check("t4_done", 64'(bus.done), 64'd1);

        // T5: out-of-range redirect, then restart from DONE
        redirect(32'd20);
        check("t5_pc20", 64'(bus.prog_count), 64'd20);
        check("t5_not_done_yet", 64'(bus.done), 64'd0);
        tick();
        check("t5_done", 64'(bus.done), 64'd1);
        tick();
        check("t5_no_push", 64'(bus.out_valid), 64'd0);
        redirect(32'd0);
        check("t5_done_drop", 64'(bus.done), 64'd0);
        check("t5_restart_pc", 64'(bus.prog_count), 64'd0);
        tick();
        check("t5_restart_head", 64'(bus.pc_out), 64'd0);

        // T6: reset in the middle of a stream
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("t6_stream_pc", 64'(bus.pc_out), 64'(e));
        end
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        check("t6_rst_pc", 64'(bus.prog_count), 64'd0);
        rst_n = 1'b1;
        tick();
        check("t6_restart_head", 64'(bus.pc_out), 64'd0);

        // Mixed ready pattern with redirects, checked by the model.
        pat = 8'b1011_0110;
        for (int i = 0; i < 40; i++) begin
            bus.out_ready = pat[i % 8];
            if (i == 15)      redirect(32'd3);
            else if (i == 30) redirect(32'd9);
            else              tick();
        end

        bus.out_ready = 1'b1;
        for (int i = 0; i < 60 && !bus.done; i++) tick();
        check("final_done", 64'(bus.done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
